// File: rtl/arb_pkg.sv
// arb_pkg: shared lane types and the round-robin pick function for rr_arb4.
package arb_pkg;
    localparam int NUM_LANES = 4;
    typedef logic [1:0] lane_id_t;
    // Lanes are searched from last+1 upward with 2-bit wrap; with no request the result is last.
    function automatic lane_id_t rr_pick(logic [NUM_LANES-1:0] req, lane_id_t last);
        lane_id_t idx;
        rr_pick = last;
        for (int k = NUM_LANES; k >= 1; k--) begin
            idx = last + lane_id_t'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction
endpackage

// File: rtl/mux2.sv
// mux2: two-way data selector.
module mux2 #(parameter int N = 8) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sel_i,
    output logic [N-1:0] y_o
);
    assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/mux4.sv
// mux4: four-way data selector built as a tree of mux2 stages.
module mux4 #(parameter int N = 8) (
    input  logic [N-1:0] d0_i,
    input  logic [N-1:0] d1_i,
    input  logic [N-1:0] d2_i,
    input  logic [N-1:0] d3_i,
    input  logic [1:0]   sel_i,
    output logic [N-1:0] y_o
);
    logic [N-1:0] lo, hi;
    mux2 #(.N(N)) u_lo (.a_i(d0_i), .b_i(d1_i), .sel_i(sel_i[0]), .y_o(lo));
    mux2 #(.N(N)) u_hi (.a_i(d2_i), .b_i(d3_i), .sel_i(sel_i[0]), .y_o(hi));
    mux2 #(.N(N)) u_top (.a_i(lo), .b_i(hi), .sel_i(sel_i[1]), .y_o(y_o));
endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: four-lane round-robin stream arbiter with a one-entry registered output.
module rr_arb4 import arb_pkg::*; #(parameter int N = 8) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_0,
    input  logic [N-1:0]   in_1,
    input  logic [N-1:0]   in_2,
    input  logic [N-1:0]   in_3,
    input  logic [3:0]     in_valid,
    output logic [3:0]     in_ready,
    output logic [N-1:0]   out,
    output lane_id_t       out_id,
    output logic           out_valid,
    input  logic           out_ready
);
    logic         load, take, out_valid_q;
    lane_id_t     sel, out_id_q, last_q;
    logic [N-1:0] mux_y, out_q;
    // rst gates in_ready so no lane believes it was accepted while the register is held clear.
    always_comb begin
        load     = !out_valid_q || out_ready;
        sel      = rr_pick(in_valid, last_q);
        take     = load && |in_valid;
        in_ready = (take && !rst) ? 4'(1) << sel : 4'b0;
    end
    mux4 #(.N(N)) u_mux (
        .d0_i(in_0), .d1_i(in_1), .d2_i(in_2), .d3_i(in_3),
        .sel_i(sel), .y_o(mux_y)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 2'd3;
        end else if (take) begin
            out_q       <= mux_y;
            out_id_q    <= sel;
            out_valid_q <= 1'b1;
            last_q      <= sel;
        end else if (load) begin
            out_valid_q <= 1'b0;
        end
    end
    assign out       = out_q;
    assign out_id    = out_id_q;
    assign out_valid = out_valid_q;
endmodule
